traffic_safety_monitor: RTL
===========================

TRAFFIC_SAFETY_MONITOR -- requirements
Module: traffic_safety_monitor

Interface
REQ-001 SHALL have parameter BLINK_HALF, default 8, meaning the number of cycles in each half-period of the fault flash.
REQ-002 SHALL have parameter FAULT_PERSIST, default 2, legal range 1..15, meaning the number of consecutive violating cycles needed to trip a fault.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports i_h_car and i_v_car, input, 4 bits each: car codes from the light sequencer. Encodings: RED 1000, YELLOW 0100, LEFT 0010, GREEN 0001, NONE 0000.
REQ-006 SHALL have ports i_h_walker and i_v_walker, input, 2 bits each: walker codes. Encodings: RED 10, GREEN 01, NONE 00.
REQ-007 SHALL have port i_fault_clear, input, 1 bit: operator request to leave FAULT.
REQ-008 SHALL have ports o_h_car_lamp and o_v_car_lamp, output, 4 bits each: car lamp drive, same encoding as the inputs.
REQ-009 SHALL have ports o_h_walker_lamp and o_v_walker_lamp, output, 2 bits each: walker lamp drive.
REQ-010 SHALL have port o_fault, output, 1 bit: high while in FAULT.
REQ-011 SHALL have port o_fault_code, output, 3 bits: latched cause of the first trip.

Function
REQ-012 SHALL implement a state machine with states IDLE, RUN and FAULT.
REQ-013 SHALL register all outputs; an output reflects the inputs sampled at the previous rising edge (1-cycle latency).
REQ-014 SHALL classify each sampled cycle as clean or violating. A cycle is violating if any of the following holds:
- (a) illegal encoding: a car code that is not one-hot and not NONE, or walker code 11;
- (b) one car code is NONE while the other is not;
- (c) car conflict: both car codes in {GREEN, LEFT, YELLOW};
- (d) i_h_walker is GREEN while i_h_car is not RED;
- (e) i_v_walker is GREEN while i_v_car is not RED.
REQ-015 SHALL assign cause codes: 1 for (a) or (b), 2 for (c), 3 for (d), 4 for (e). If several causes occur in the same cycle, the lowest code wins.
REQ-016 SHALL use a persistence counter (4 bits):
- increments on each violating cycle, saturating at 15;
- clears to 0 on any clean cycle.
REQ-017 IDLE: all outputs drive NONE. The block moves to RUN when a sampled cycle has both car codes non-NONE and is clean.
REQ-018 RUN, clean cycle: outputs equal the sampled inputs unchanged. All walker codes pass through, including NONE used for walker blink.
REQ-019 RUN, violating cycle: outputs are forced to car RED / walker RED.
REQ-020 RUN to IDLE: when all four sampled codes are NONE (sequencer stopped).
REQ-021 RUN to FAULT: on the cycle the persistence counter reaches FAULT_PERSIST. On that transition, o_fault_code latches the cause of that cycle.
REQ-022 FAULT:
- both car lamps flash RED/NONE, starting RED on the first FAULT cycle and toggling every BLINK_HALF cycles;
- walker lamps hold RED;
- o_fault = 1;
- input changes are ignored.
REQ-023 FAULT to IDLE: only when i_fault_clear = 1 and all four sampled codes are NONE in the same cycle. On exit, o_fault and o_fault_code clear to 0. i_fault_clear has no effect in IDLE or RUN.
REQ-024 SHALL use a blink counter of width clog2(BLINK_HALF); it is reset to 0 on FAULT entry and wraps at BLINK_HALF-1.

Reset
REQ-025 SHALL, when reset = 1 at a rising edge, set: state IDLE, all lamps NONE, o_fault 0, o_fault_code 0, persistence and blink counters 0.
REQ-026 SHALL give reset priority over every transition, including mid-FAULT and mid-blink.

Structure
REQ-027 SHALL place the car/walker encoding constants, the state enum and the cause-code constants in a shared package, traffic_pkg, also used by the sequencer.
REQ-028 SHALL implement the violation classifier as a combinational sub-module, traffic_rule_check, which outputs a violation flag and a 3-bit cause.

Verification
REQ-029 Nominal 68-cycle sequencer loop (H GREEN/V RED, then H RED/V GREEN, walker blink as 01/00): outputs equal the inputs delayed 1 cycle; o_fault remains 0.
REQ-030 i_h_car = GREEN and i_v_car = GREEN for 1 cycle, then clean: lamps all RED for 1 cycle, then pass-through resumes; o_fault remains 0.
REQ-031 Same conflict held for 2 cycles: o_fault = 1 and o_fault_code = 2; car lamps show RED for 8 cycles, NONE for 8, RED for 8.
REQ-032 i_v_walker = GREEN with i_v_car = GREEN, and i_h_car = 0110, both held for 2 cycles: o_fault_code = 1 (lowest code wins).
REQ-033 In FAULT, i_fault_clear = 1 with inputs non-NONE: stays in FAULT. Then all inputs NONE with i_fault_clear = 1: next cycle IDLE with o_fault = 0 and o_fault_code = 0.
REQ-034 reset = 1 asserted mid-blink in FAULT: next cycle all lamps NONE, o_fault = 0 and o_fault_code = 0.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared lamp encodings, monitor states and trip cause codes for the traffic controller.
package traffic_pkg;

    localparam logic [3:0] CAR_RED    = 4'b1000;
    localparam logic [3:0] CAR_YELLOW = 4'b0100;
    localparam logic [3:0] CAR_LEFT   = 4'b0010;
    localparam logic [3:0] CAR_GREEN  = 4'b0001;
    localparam logic [3:0] CAR_NONE   = 4'b0000;

    localparam logic [1:0] WALK_RED   = 2'b10;
    localparam logic [1:0] WALK_GREEN = 2'b01;
    localparam logic [1:0] WALK_NONE  = 2'b00;
    localparam logic [1:0] WALK_BAD   = 2'b11;

    localparam logic [2:0] CAUSE_NONE     = 3'd0;
    localparam logic [2:0] CAUSE_ENCODING = 3'd1;
    localparam logic [2:0] CAUSE_CONFLICT = 3'd2;
    localparam logic [2:0] CAUSE_H_WALK   = 3'd3;
    localparam logic [2:0] CAUSE_V_WALK   = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    function automatic logic car_legal(input logic [3:0] code);
        return (code == CAR_NONE) || $onehot(code);
    endfunction

    function automatic logic car_moving(input logic [3:0] code);
        return (code == CAR_GREEN) || (code == CAR_LEFT) || (code == CAR_YELLOW);
    endfunction

endpackage

// File: rtl/traffic_rule_check.sv
// Combinational classifier: flags an unsafe lamp combination and reports the
// lowest-numbered cause present in the same cycle.
module traffic_rule_check
    import traffic_pkg::*;
(
    input  logic [3:0] h_car_i,
    input  logic [3:0] v_car_i,
    input  logic [1:0] h_walker_i,
    input  logic [1:0] v_walker_i,
    output logic       viol_o,
    output logic [2:0] cause_o
);

    logic bad_enc;
    logic car_conflict;
    logic h_walk_unsafe;
    logic v_walk_unsafe;

    always_comb begin
        bad_enc = !car_legal(h_car_i) || !car_legal(v_car_i)
               || (h_walker_i == WALK_BAD) || (v_walker_i == WALK_BAD)
               || ((h_car_i == CAR_NONE) != (v_car_i == CAR_NONE));
        car_conflict  = car_moving(h_car_i) && car_moving(v_car_i);
        h_walk_unsafe = (h_walker_i == WALK_GREEN) && (h_car_i != CAR_RED);
        v_walk_unsafe = (v_walker_i == WALK_GREEN) && (v_car_i != CAR_RED);

        viol_o  = 1'b1;
        cause_o = CAUSE_NONE;
        if (bad_enc) begin
            cause_o = CAUSE_ENCODING;
        end else if (car_conflict) begin
            cause_o = CAUSE_CONFLICT;
        end else if (h_walk_unsafe) begin
            cause_o = CAUSE_H_WALK;
        end else if (v_walk_unsafe) begin
            cause_o = CAUSE_V_WALK;
        end else begin
            viol_o = 1'b0;
        end
    end

endmodule

// File: rtl/traffic_safety_monitor.sv
// Registered safety gate between the light sequencer and the lamp drivers:
// passes safe codes with 1-cycle latency, forces RED on violations, and latches a flashing FAULT.
module traffic_safety_monitor
    import traffic_pkg::*;
#(
    parameter int BLINK_HALF    = 8,
    parameter int FAULT_PERSIST = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] i_h_car,
    input  logic [3:0] i_v_car,
    input  logic [1:0] i_h_walker,
    input  logic [1:0] i_v_walker,
    input  logic       i_fault_clear,
    output logic [3:0] o_h_car_lamp,
    output logic [3:0] o_v_car_lamp,
    output logic [1:0] o_h_walker_lamp,
    output logic [1:0] o_v_walker_lamp,
    output logic       o_fault,
    output logic [2:0] o_fault_code
);

    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam logic [3:0]    PERSIST_TRIP = 4'(FAULT_PERSIST);

    state_t        state_q, state_d;
    logic [3:0]    persist_q, persist_d;
    logic [BW-1:0] blink_q, blink_d;
    logic [3:0]    h_car_q, h_car_d, v_car_q, v_car_d;
    logic [1:0]    h_walk_q, h_walk_d, v_walk_q, v_walk_d;
    logic          fault_q, fault_d;
    logic [2:0]    code_q, code_d;

    logic          viol;
    logic [2:0]    cause;
    logic          all_none;

    traffic_rule_check u_rule_check (
        .h_car_i    (i_h_car),
        .v_car_i    (i_v_car),
        .h_walker_i (i_h_walker),
        .v_walker_i (i_v_walker),
        .viol_o     (viol),
        .cause_o    (cause)
    );

    assign all_none = (i_h_car == CAR_NONE) && (i_v_car == CAR_NONE)
                   && (i_h_walker == WALK_NONE) && (i_v_walker == WALK_NONE);

    always_comb begin
        state_d  = state_q;
        blink_d  = blink_q;
        h_car_d  = h_car_q;
        v_car_d  = v_car_q;
        h_walk_d = h_walk_q;
        v_walk_d = v_walk_q;
        fault_d  = fault_q;
        code_d   = code_q;
        if (!viol) begin
            persist_d = 4'd0;
        end else if (persist_q == 4'hF) begin
            persist_d = persist_q;
        end else begin
            persist_d = persist_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                h_car_d  = CAR_NONE;
                v_car_d  = CAR_NONE;
                h_walk_d = WALK_NONE;
                v_walk_d = WALK_NONE;
                // The first clean cycle is already driven to the lamps, so latency stays 1.
                if (!viol && (i_h_car != CAR_NONE) && (i_v_car != CAR_NONE)) begin
                    state_d  = ST_RUN;
                    h_car_d  = i_h_car;
                    v_car_d  = i_v_car;
                    h_walk_d = i_h_walker;
                    v_walk_d = i_v_walker;
                end
            end
            ST_RUN: begin
                if (viol) begin
                    h_car_d  = CAR_RED;
                    v_car_d  = CAR_RED;
                    h_walk_d = WALK_RED;
                    v_walk_d = WALK_RED;
                    if (persist_d == PERSIST_TRIP) begin
                        state_d = ST_FAULT;
                        fault_d = 1'b1;
                        code_d  = cause;
                        blink_d = '0;
                    end
                end else begin
                    h_car_d  = i_h_car;
                    v_car_d  = i_v_car;
                    h_walk_d = i_h_walker;
                    v_walk_d = i_v_walker;
                    if (all_none) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_FAULT: begin
                h_walk_d = WALK_RED;
                v_walk_d = WALK_RED;
                if (i_fault_clear && all_none) begin
                    state_d  = ST_IDLE;
                    h_car_d  = CAR_NONE;
                    v_car_d  = CAR_NONE;
                    h_walk_d = WALK_NONE;
                    v_walk_d = WALK_NONE;
                    fault_d  = 1'b0;
                    code_d   = CAUSE_NONE;
                    blink_d  = '0;
                end else if (blink_q == BLINK_LAST) begin
                    blink_d = '0;
                    h_car_d = (h_car_q == CAR_RED) ? CAR_NONE : CAR_RED;
                    v_car_d = (h_car_q == CAR_RED) ? CAR_NONE : CAR_RED;
                end else begin
                    blink_d = blink_q + BW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            persist_q <= 4'd0;
            blink_q   <= '0;
            h_car_q   <= CAR_NONE;
            v_car_q   <= CAR_NONE;
            h_walk_q  <= WALK_NONE;
            v_walk_q  <= WALK_NONE;
            fault_q   <= 1'b0;
            code_q    <= CAUSE_NONE;
        end else begin
            state_q   <= state_d;
            persist_q <= persist_d;
            blink_q   <= blink_d;
            h_car_q   <= h_car_d;
            v_car_q   <= v_car_d;
            h_walk_q  <= h_walk_d;
            v_walk_q  <= v_walk_d;
            fault_q   <= fault_d;
            code_q    <= code_d;
        end
    end

    assign o_h_car_lamp    = h_car_q;
    assign o_v_car_lamp    = v_car_q;
    assign o_h_walker_lamp = h_walk_q;
    assign o_v_walker_lamp = v_walk_q;
    assign o_fault         = fault_q;
    assign o_fault_code    = code_q;

endmodule
